// File: rtl/serv_bus_arbiter.sv
// serv_bus_arbiter: shares one Wishbone slave port between the SERV
// instruction bus and data bus. A registered three-state grant FSM runs one
// transaction at a time; simultaneous requests alternate round-robin.
//
// Optional feature: define SERV_ARB_TIMEOUT_EN to enable a watchdog that
// terminates a transaction the slave never acknowledges. Without the macro
// the grant is held until i_wb_ack and o_timeout is tied low.

module serv_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned TW             = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic        clk,
    input  logic        i_rst_n,
    // Instruction bus (read only)
    input  logic [31:0] i_ibus_adr,
    input  logic        i_ibus_cyc,
    output logic [31:0] o_ibus_rdt,
    output logic        o_ibus_ack,
    // Data bus
    input  logic [31:0] i_dbus_adr,
    input  logic [31:0] i_dbus_dat,
    input  logic [3:0]  i_dbus_sel,
    input  logic        i_dbus_we,
    input  logic        i_dbus_cyc,
    output logic [31:0] o_dbus_rdt,
    output logic        o_dbus_ack,
    // Shared slave bus
    output logic [31:0] o_wb_adr,
    output logic [31:0] o_wb_dat,
    output logic [3:0]  o_wb_sel,
    output logic        o_wb_we,
    output logic        o_wb_cyc,
    input  logic [31:0] i_wb_rdt,
    input  logic        i_wb_ack,
    // Sticky watchdog flag
    output logic        o_timeout
);

    typedef enum logic [1:0] {
        StIdle,
        StGntI,
        StGntD
    } state_e;

    // Encoding of the last-served master
    localparam logic LastIbus = 1'b0;
    localparam logic LastDbus = 1'b1;

    state_e      state_q, state_d;
    logic        last_q, last_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic [3:0]  sel_q, sel_d;
    logic        we_q, we_d;
    logic        cyc_q, cyc_d;

    logic        granted;
    logic        timeout_hit;
    logic        done;

    assign granted = (state_q == StGntI) || (state_q == StGntD);

`ifdef SERV_ARB_TIMEOUT_EN
    logic [TW-1:0] cnt_q, cnt_d;
    logic          timeout_q, timeout_d;

    // A real slave ack in the limit cycle wins over the watchdog
    assign timeout_hit = granted && !i_wb_ack && (cnt_q == TW'(TIMEOUT_CYCLES));

    // Watchdog counter: zero while idle so every grant starts from 0; flag is sticky
    always_comb begin
        cnt_d     = cnt_q;
        timeout_d = timeout_q | timeout_hit;
        if (!granted) begin
            cnt_d = '0;
        end else if (!i_wb_ack && (cnt_q != TW'(TIMEOUT_CYCLES))) begin
            cnt_d = cnt_q + TW'(1);
        end
    end

    // Watchdog state registers
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_timeout = timeout_q;
`else
    assign timeout_hit = 1'b0;
    assign o_timeout   = 1'b0;
`endif

    // A grant ends on a slave ack or on a watchdog expiry
    assign done = i_wb_ack | timeout_hit;

    // Grant FSM next-state and request-register load logic
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        we_d    = we_q;
        cyc_d   = cyc_q;

        case (state_q)
            StIdle: begin
                // On a tie the master that was not served last wins
                if (i_ibus_cyc && (!i_dbus_cyc || (last_q == LastDbus))) begin
                    state_d = StGntI;
                    adr_d   = i_ibus_adr;
                    dat_d   = '0;
                    sel_d   = 4'hF;
                    we_d    = 1'b0;
                    cyc_d   = 1'b1;
                end else if (i_dbus_cyc) begin
                    state_d = StGntD;
                    adr_d   = i_dbus_adr;
                    dat_d   = i_dbus_dat;
                    sel_d   = i_dbus_sel;
                    we_d    = i_dbus_we;
                    cyc_d   = 1'b1;
                end
            end
            StGntI: begin
                if (done) begin
                    state_d = StIdle;
                    cyc_d   = 1'b0;
                    last_d  = LastIbus;
                end
            end
            StGntD: begin
                if (done) begin
                    state_d = StIdle;
                    cyc_d   = 1'b0;
                    last_d  = LastDbus;
                end
            end
            default: begin
                state_d = StIdle;
                cyc_d   = 1'b0;
            end
        endcase
    end

    // FSM and registered shared-bus request
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
            last_q  <= LastDbus;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            cyc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            cyc_q   <= cyc_d;
        end
    end

    assign o_wb_adr = adr_q;
    assign o_wb_dat = dat_q;
    assign o_wb_sel = sel_q;
    assign o_wb_we  = we_q;
    assign o_wb_cyc = cyc_q;

    // Zero-latency ack routing; read data is shared and only meaningful with ack
    assign o_ibus_ack = (state_q == StGntI) && done;
    assign o_dbus_ack = (state_q == StGntD) && done;
    assign o_ibus_rdt = timeout_hit ? 32'h0 : i_wb_rdt;
    assign o_dbus_rdt = timeout_hit ? 32'h0 : i_wb_rdt;

endmodule

// File: tb/tb_serv_bus_arbiter.sv
// Directed self-checking bench for serv_bus_arbiter. Inputs change and outputs
// are sampled 1 time unit after the rising edge.

module tb_serv_bus_arbiter;

    logic        clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic [31:0] i_ibus_adr = '0;
    logic        i_ibus_cyc = 1'b0;
    logic [31:0] o_ibus_rdt;
    logic        o_ibus_ack;
    logic [31:0] i_dbus_adr = '0;
    logic [31:0] i_dbus_dat = '0;
    logic [3:0]  i_dbus_sel = '0;
    logic        i_dbus_we = 1'b0;
    logic        i_dbus_cyc = 1'b0;
    logic [31:0] o_dbus_rdt;
    logic        o_dbus_ack;
    logic [31:0] o_wb_adr;
    logic [31:0] o_wb_dat;
    logic [3:0]  o_wb_sel;
    logic        o_wb_we;
    logic        o_wb_cyc;
    logic [31:0] i_wb_rdt = '0;
    logic        i_wb_ack = 1'b0;
    logic        o_timeout;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    serv_bus_arbiter #(
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk        (clk),
        .i_rst_n    (i_rst_n),
        .i_ibus_adr (i_ibus_adr),
        .i_ibus_cyc (i_ibus_cyc),
        .o_ibus_rdt (o_ibus_rdt),
        .o_ibus_ack (o_ibus_ack),
        .i_dbus_adr (i_dbus_adr),
        .i_dbus_dat (i_dbus_dat),
        .i_dbus_sel (i_dbus_sel),
        .i_dbus_we  (i_dbus_we),
        .i_dbus_cyc (i_dbus_cyc),
        .o_dbus_rdt (o_dbus_rdt),
        .o_dbus_ack (o_dbus_ack),
        .o_wb_adr   (o_wb_adr),
        .o_wb_dat   (o_wb_dat),
        .o_wb_sel   (o_wb_sel),
        .o_wb_we    (o_wb_we),
        .o_wb_cyc   (o_wb_cyc),
        .i_wb_rdt   (i_wb_rdt),
        .i_wb_ack   (i_wb_ack),
        .o_timeout  (o_timeout)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        tick();
        i_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        tick();
        n_cmp++;
        if ({o_wb_cyc, o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we} !== 70'h0) begin
            n_bad++;
            $display("FAIL reset_wb: got cyc=%b adr=%h dat=%h sel=%h we=%b want all 0",
                     o_wb_cyc, o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we);
        end
        n_cmp++;
        if ({o_ibus_ack, o_dbus_ack, o_timeout} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_flags: got iack=%b dack=%b to=%b want 000",
                     o_ibus_ack, o_dbus_ack, o_timeout);
        end
        i_rst_n = 1'b1;
        tick();
        n_cmp++;
        if (o_wb_cyc !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_idle: got cyc=%b want 0", o_wb_cyc);
        end
    endtask

    task automatic test_single_fetch();
        i_ibus_adr = 32'h100;
        i_ibus_cyc = 1'b1;
        tick();
        n_cmp++;
        if ({o_wb_cyc, o_wb_adr, o_wb_we, o_wb_sel, o_wb_dat} !== {1'b1, 32'h100, 1'b0, 4'hF, 32'h0})
            begin
            n_bad++;
            $display("FAIL fetch_req: got cyc=%b adr=%h we=%b sel=%h dat=%h want 1 100 0 f 0",
                     o_wb_cyc, o_wb_adr, o_wb_we, o_wb_sel, o_wb_dat);
        end
        tick();
        tick();
        n_cmp++;
        if ({o_ibus_ack, o_dbus_ack, o_wb_cyc} !== 3'b001) begin
            n_bad++;
            $display("FAIL fetch_wait: got iack=%b dack=%b cyc=%b want 0 0 1",
                     o_ibus_ack, o_dbus_ack, o_wb_cyc);
        end
        tick();
        i_wb_ack = 1'b1;
        i_wb_rdt = 32'hDEADBEEF;
        #1;
        n_cmp++;
        if ({o_ibus_ack, o_dbus_ack, o_ibus_rdt} !== {2'b10, 32'hDEADBEEF}) begin
            n_bad++;
            $display("FAIL fetch_ack: got iack=%b dack=%b rdt=%h want 1 0 deadbeef",
                     o_ibus_ack, o_dbus_ack, o_ibus_rdt);
        end
        tick();
        i_wb_ack = 1'b0;
        i_ibus_cyc = 1'b0;
        #1;
        n_cmp++;
        if ({o_ibus_ack, o_wb_cyc} !== 2'b00) begin
            n_bad++;
            $display("FAIL fetch_end: got iack=%b cyc=%b want 0 0", o_ibus_ack, o_wb_cyc);
        end
    endtask

    task automatic test_data_write();
        logic stable;
        i_dbus_adr = 32'h2000;
        i_dbus_dat = 32'h12345678;
        i_dbus_sel = 4'h3;
        i_dbus_we  = 1'b1;
        i_dbus_cyc = 1'b1;
        tick();
        n_cmp++;
        if ({o_wb_cyc, o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we} !==
            {1'b1, 32'h2000, 32'h12345678, 4'h3, 1'b1}) begin
            n_bad++;
            $display("FAIL write_req: got cyc=%b adr=%h dat=%h sel=%h we=%b want 1 2000 12345678 3 1",
                     o_wb_cyc, o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we);
        end
        // Disturb the master inputs: the registered request must not follow
        i_dbus_adr = 32'hFFFF_0000;
        i_dbus_dat = 32'h0;
        i_dbus_sel = 4'hC;
        i_dbus_we  = 1'b0;
        stable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if ({o_wb_cyc, o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we} !==
                {1'b1, 32'h2000, 32'h12345678, 4'h3, 1'b1}) stable = 1'b0;
        end
        n_cmp++;
        if (stable !== 1'b1) begin
            n_bad++;
            $display("FAIL write_hold: got adr=%h dat=%h sel=%h we=%b want 2000 12345678 3 1",
                     o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we);
        end
        i_wb_ack = 1'b1;
        #1;
        n_cmp++;
        if ({o_dbus_ack, o_ibus_ack, o_wb_cyc} !== 3'b101) begin
            n_bad++;
            $display("FAIL write_ack: got dack=%b iack=%b cyc=%b want 1 0 1",
                     o_dbus_ack, o_ibus_ack, o_wb_cyc);
        end
        tick();
        i_wb_ack = 1'b0;
        i_dbus_cyc = 1'b0;
        n_cmp++;
        if (o_wb_cyc !== 1'b0) begin
            n_bad++;
            $display("FAIL write_end: got cyc=%b want 0", o_wb_cyc);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_adr [3];
        exp_adr[0] = 32'h300;
        exp_adr[1] = 32'h400;
        exp_adr[2] = 32'h300;
        do_reset();
        i_ibus_adr = 32'h300;
        i_dbus_adr = 32'h400;
        i_dbus_we  = 1'b0;
        i_dbus_sel = 4'hF;
        i_ibus_cyc = 1'b1;
        i_dbus_cyc = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++;
            if ({o_wb_cyc, o_wb_adr} !== {1'b1, exp_adr[k]}) begin
                n_bad++;
                $display("FAIL rr_grant%0d: got cyc=%b adr=%h want 1 %h",
                         k, o_wb_cyc, o_wb_adr, exp_adr[k]);
            end
            i_wb_ack = 1'b1;
            #1;
            n_cmp++;
            if ({o_ibus_ack, o_dbus_ack} !== ((k == 1) ? 2'b01 : 2'b10)) begin
                n_bad++;
                $display("FAIL rr_ack%0d: got iack=%b dack=%b", k, o_ibus_ack, o_dbus_ack);
            end
            tick();
            i_wb_ack = 1'b0;
            n_cmp++;
            if (o_wb_cyc !== 1'b0) begin
                n_bad++;
                $display("FAIL rr_idle%0d: got cyc=%b want 0", k, o_wb_cyc);
            end
        end
        i_ibus_cyc = 1'b0;
        i_dbus_cyc = 1'b0;
        tick();
    endtask

    task automatic test_async_reset();
        i_dbus_adr = 32'h800;
        i_dbus_cyc = 1'b1;
        tick();
        n_cmp++;
        if ({o_wb_cyc, o_wb_adr} !== {1'b1, 32'h800}) begin
            n_bad++;
            $display("FAIL areset_grant: got cyc=%b adr=%h want 1 800", o_wb_cyc, o_wb_adr);
        end
        #2;
        i_wb_ack = 1'b1;
        i_rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({o_wb_cyc, o_dbus_ack, o_wb_adr} !== {2'b00, 32'h0}) begin
            n_bad++;
            $display("FAIL areset_clear: got cyc=%b dack=%b adr=%h want 0 0 0",
                     o_wb_cyc, o_dbus_ack, o_wb_adr);
        end
        i_dbus_cyc = 1'b0;
        i_wb_ack = 1'b0;
        tick();
        i_rst_n = 1'b1;
        tick();
        n_cmp++;
        if (o_wb_cyc !== 1'b0) begin
            n_bad++;
            $display("FAIL areset_idle: got cyc=%b want 0", o_wb_cyc);
        end
    endtask

    task automatic test_spurious_ack();
        i_wb_ack = 1'b1;
        #1;
        n_cmp++;
        if ({o_ibus_ack, o_dbus_ack} !== 2'b00) begin
            n_bad++;
            $display("FAIL spur_ack: got iack=%b dack=%b want 0 0", o_ibus_ack, o_dbus_ack);
        end
        tick();
        i_wb_ack = 1'b0;
        n_cmp++;
        if (o_wb_cyc !== 1'b0) begin
            n_bad++;
            $display("FAIL spur_state: got cyc=%b want 0", o_wb_cyc);
        end
        // Arbiter must still grant normally afterwards
        i_dbus_adr = 32'hA00;
        i_dbus_cyc = 1'b1;
        tick();
        n_cmp++;
        if ({o_wb_cyc, o_wb_adr} !== {1'b1, 32'hA00}) begin
            n_bad++;
            $display("FAIL spur_next: got cyc=%b adr=%h want 1 a00", o_wb_cyc, o_wb_adr);
        end
        i_wb_ack = 1'b1;
        tick();
        i_wb_ack = 1'b0;
        i_dbus_cyc = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        logic ok;
        i_dbus_adr = 32'h500;
        i_dbus_we  = 1'b0;
        i_dbus_cyc = 1'b1;
        i_wb_rdt   = 32'hFFFF_FFFF;
        tick();
`ifdef SERV_ARB_TIMEOUT_EN
        ok = 1'b1;
        for (int i = 1; i < 8; i++) begin
            tick();
            if ({o_dbus_ack, o_wb_cyc} !== 2'b01) ok = 1'b0;
        end
        n_cmp++;
        if (ok !== 1'b1) begin
            n_bad++;
            $display("FAIL to_early: got dack=%b cyc=%b before limit", o_dbus_ack, o_wb_cyc);
        end
        tick();
        n_cmp++;
        if ({o_dbus_ack, o_ibus_ack, o_dbus_rdt} !== {2'b10, 32'h0}) begin
            n_bad++;
            $display("FAIL to_ack: got dack=%b iack=%b rdt=%h want 1 0 0",
                     o_dbus_ack, o_ibus_ack, o_dbus_rdt);
        end
        tick();
        i_dbus_cyc = 1'b0;
        n_cmp++;
        if ({o_wb_cyc, o_timeout} !== 2'b01) begin
            n_bad++;
            $display("FAIL to_flag: got cyc=%b to=%b want 0 1", o_wb_cyc, o_timeout);
        end
        for (int i = 0; i < 5; i++) tick();
        n_cmp++;
        if (o_timeout !== 1'b1) begin
            n_bad++;
            $display("FAIL to_sticky: got to=%b want 1", o_timeout);
        end
`else
        ok = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if ({o_wb_cyc, o_dbus_ack, o_timeout} !== 3'b100) ok = 1'b0;
        end
        n_cmp++;
        if (ok !== 1'b1) begin
            n_bad++;
            $display("FAIL no_to_hold: got cyc=%b dack=%b to=%b want 1 0 0",
                     o_wb_cyc, o_dbus_ack, o_timeout);
        end
        i_wb_ack = 1'b1;
        #1;
        n_cmp++;
        if (o_dbus_ack !== 1'b1) begin
            n_bad++;
            $display("FAIL no_to_ack: got dack=%b want 1", o_dbus_ack);
        end
        tick();
        i_wb_ack = 1'b0;
        i_dbus_cyc = 1'b0;
        tick();
`endif
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_data_write();
        test_back_to_back();
        test_async_reset();
        test_spurious_ack();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
